// File: rtl/bo_pkg.sv
// Shared widths, operand-select encodings and ALU op codes for the polynomial datapath.
package bo_pkg;

    localparam int unsigned W = 16;

    // Coefficient mux select
    typedef enum logic [1:0] {
        SEL0_ZERO = 2'd0,
        SEL0_A    = 2'd1,
        SEL0_B    = 2'd2,
        SEL0_C    = 2'd3
    } sel0_e;

    // ALU operand-1 select
    typedef enum logic [1:0] {
        SEL1_M0 = 2'd0,
        SEL1_R0 = 2'd1,
        SEL1_R1 = 2'd2,
        SEL1_R2 = 2'd3
    } sel1_e;

    // ALU operand-2 select
    typedef enum logic [1:0] {
        SEL2_R0 = 2'd0,
        SEL2_M0 = 2'd1,
        SEL2_R1 = 2'd2,
        SEL2_R2 = 2'd3
    } sel2_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/bo_datapath_if.sv
// Control/data bundle between the sequencing controller (master) and the datapath (slave).
interface bo_datapath_if;
    import bo_pkg::*;

    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] C;
    logic [1:0]   M0;
    logic [W-1:0] x;
    logic         LX;
    logic [1:0]   M1;
    logic [1:0]   M2;
    logic         LH;
    logic         LS;
    logic         H;
    logic [W-1:0] Pronto;

    modport master (
        output A, B, C, M0, x, LX, M1, M2, LH, LS, H,
        input  Pronto
    );

    modport slave (
        input  A, B, C, M0, x, LX, M1, M2, LH, LS, H,
        output Pronto
    );

endinterface

// File: rtl/bo_reg.sv
// W-bit register with synchronous active-high clear and load enable; clear wins.
module bo_reg
    import bo_pkg::*;
#(
    parameter int unsigned WIDTH = W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear on reset, capture on load, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/bo_datapath.sv
// Polynomial datapath: x register R0, work registers R1/R2, three operand muxes
// and a shared add/multiply unit. R2 is the visible result.
module bo_datapath
    import bo_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    bo_datapath_if.slave bus
);

    logic [W-1:0] w_r0;
    logic [W-1:0] w_r1;
    logic [W-1:0] w_r2;
    logic [W-1:0] w_m0out;
    logic [W-1:0] w_op1;
    logic [W-1:0] w_op2;
    logic [W-1:0] w_alu;

    // Coefficient select
    always_comb begin
        w_m0out = '0;
        case (bus.M0)
            SEL0_ZERO: w_m0out = '0;
            SEL0_A:    w_m0out = bus.A;
            SEL0_B:    w_m0out = bus.B;
            SEL0_C:    w_m0out = bus.C;
            default:   w_m0out = '0;
        endcase
    end

    // ALU operand 1 select
    always_comb begin
        w_op1 = '0;
        case (bus.M1)
            SEL1_M0: w_op1 = w_m0out;
            SEL1_R0: w_op1 = w_r0;
            SEL1_R1: w_op1 = w_r1;
            SEL1_R2: w_op1 = w_r2;
            default: w_op1 = '0;
        endcase
    end

    // ALU operand 2 select
    always_comb begin
        w_op2 = '0;
        case (bus.M2)
            SEL2_R0: w_op2 = w_r0;
            SEL2_M0: w_op2 = w_m0out;
            SEL2_R1: w_op2 = w_r1;
            SEL2_R2: w_op2 = w_r2;
            default: w_op2 = '0;
        endcase
    end

    // Unsigned add or multiply, truncated to W bits (wraps silently)
    always_comb begin
        if (bus.H == OP_MUL) begin
            w_alu = w_op1 * w_op2;
        end else begin
            w_alu = w_op1 + w_op2;
        end
    end

    bo_reg #(.WIDTH(W)) u_r0 (
        .clk  (clk),
        .rst  (rst),
        .i_ld (bus.LX),
        .i_d  (bus.x),
        .o_q  (w_r0)
    );

    bo_reg #(.WIDTH(W)) u_r1 (
        .clk  (clk),
        .rst  (rst),
        .i_ld (bus.LH),
        .i_d  (w_alu),
        .o_q  (w_r1)
    );

    bo_reg #(.WIDTH(W)) u_r2 (
        .clk  (clk),
        .rst  (rst),
        .i_ld (bus.LS),
        .i_d  (w_alu),
        .o_q  (w_r2)
    );

    assign bus.Pronto = w_r2;

endmodule

// File: tb/tb_bo_datapath.sv
// Directed bench for bo_datapath: a register-level reference model checked every
// cycle against the DUT registers and Pronto, plus literal spot checks.
module tb_bo_datapath;

    logic clk;
    logic rst;

    bo_datapath_if bus ();

    bo_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    logic [15:0] m_r0, m_r1, m_r2;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pick operands by index into value lists, combine with 32-bit math mod 2^16
    function automatic logic [15:0] model_alu();
        logic [15:0] coef [4];
        logic [15:0] s1 [4];
        logic [15:0] s2 [4];
        int unsigned a, b, r;
        coef = '{16'd0, bus.A, bus.B, bus.C};
        s1   = '{coef[bus.M0], m_r0, m_r1, m_r2};
        s2   = '{m_r0, coef[bus.M0], m_r1, m_r2};
        a = s1[bus.M1];
        b = s2[bus.M2];
        r = bus.H ? (a * b) % 65536 : (a + b) % 65536;
        return r[15:0];
    endfunction

    always @(posedge clk) begin
        logic [15:0] alu;
        alu = model_alu();
        if (rst) begin
            m_r0 <= 16'd0;
            m_r1 <= 16'd0;
            m_r2 <= 16'd0;
        end else begin
            if (bus.LX) m_r0 <= bus.x;
            if (bus.LH) m_r1 <= alu;
            if (bus.LS) m_r2 <= alu;
        end
    end

    // Single per-cycle compare, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_Pronto", bus.Pronto, m_r2);
            chk("cyc_R0", dut.w_r0, m_r0);
            chk("cyc_R1", dut.w_r1, m_r1);
            chk("cyc_R2", dut.w_r2, m_r2);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.LX = 1'b0;
        bus.LH = 1'b0;
        bus.LS = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic op(input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2,
                      input logic h, input logic lh, input logic ls);
        bus.M0 = m0;
        bus.M1 = m1;
        bus.M2 = m2;
        bus.H  = h;
        bus.LH = lh;
        bus.LS = ls;
        cyc();
    endtask

    task automatic load_x(input logic [15:0] v);
        bus.x  = v;
        bus.LX = 1'b1;
        cyc();
    endtask

    // 1*x^2 + 0*x + 3 with x=4; optional reset on the final LS cycle
    task automatic poly_seq(input bit rst_at_end);
        load_x(16'd4);
        op(2'd0, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("lit_square", dut.w_r1, 16'd16);
        bus.A = 16'd1;
        op(2'd1, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0);
        chk("lit_AxR1", dut.w_r1, 16'd16);
        chk("lit_R0_held", dut.w_r0, 16'd4);
        bus.C = 16'd3;
        rst = rst_at_end;
        op(2'd3, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.A = '0; bus.B = '0; bus.C = '0; bus.x = 16'h5A5A;
        bus.M0 = '0; bus.M1 = '0; bus.M2 = '0; bus.H = 1'b0;
        bus.LX = 1'b1; bus.LH = 1'b1; bus.LS = 1'b1;
        rst = 1'b1;

        // Reset with every enable high
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.LX = 1'b0; bus.LH = 1'b0; bus.LS = 1'b0;
        cmp_en = 1'b1;
        chk("lit_rst_Pronto", bus.Pronto, 16'd0);
        chk("lit_rst_R0", dut.w_r0, 16'd0);
        chk("lit_rst_R1", dut.w_r1, 16'd0);

        // Polynomial evaluation
        poly_seq(1'b0);
        chk("lit_poly", bus.Pronto, 16'd19);
        chk("lit_model_poly", m_r2, 16'd19);

        // Add wrap: A=2 + R0=0xFFFF
        load_x(16'hFFFF);
        bus.A = 16'd2;
        op(2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("lit_add_wrap", dut.w_r1, 16'h0001);

        // Multiply wrap: R0*R0 with R0=0x0100
        load_x(16'h0100);
        op(2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1);
        chk("lit_mul_wrap", bus.Pronto, 16'h0000);

        // Zero coefficient: add passes the other operand, multiply gives 0
        load_x(16'h1234);
        op(2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
        chk("lit_zero_add", bus.Pronto, 16'h1234);
        op(2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        chk("lit_zero_mul", bus.Pronto, 16'h0000);

        // LH and LS together: R0+R0 with R0=4
        load_x(16'd4);
        op(2'd0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b1);
        chk("lit_dual_R1", dut.w_r1, 16'd8);
        chk("lit_dual_R2", bus.Pronto, 16'd8);

        // LX alongside LH: ALU sees old R0
        bus.x = 16'd7;
        bus.LX = 1'b1;
        op(2'd0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("lit_lx_old_R1", dut.w_r1, 16'd8);
        chk("lit_lx_new_R0", dut.w_r0, 16'd7);

        // Read-modify-write R1 <= R1*R0
        op(2'd0, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("lit_rmw", dut.w_r1, 16'd56);

        // B coefficient and R2 as operand: R2 <= B + R2 (8 + 0x0105)
        bus.B = 16'h0105;
        op(2'd2, 2'd3, 2'd1, 1'b0, 1'b0, 1'b1);
        chk("lit_B_R2", bus.Pronto, 16'h010D);

        // Reset on the final step discards everything, then rerun
        poly_seq(1'b1);
        chk("lit_midrst_Pronto", bus.Pronto, 16'd0);
        chk("lit_midrst_R1", dut.w_r1, 16'd0);
        poly_seq(1'b0);
        chk("lit_rerun", bus.Pronto, 16'd19);

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
